p2s_ctrl: RTL and testbench

Word-slot sequencer for the parallel-to-serial path. It accepts 8-bit words over a valid/ready handshake and buffers one word. It drives the 3-bit select of the 8:1 bit multiplexer (`mux_p2s`) so each word goes out LSB first, one bit per clock. When no word is pending at a slot boundary, it fills the slot with an idle/comma symbol, so the serial line never starves while enabled.

---
 rtl/p2s_ctrl_pkg.sv | 16 +
 rtl/mux_p2s.sv | 12 +
 rtl/p2s_ctrl.sv | 121 ++++++++++++
 tb/tb_p2s_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/p2s_ctrl_pkg.sv
// Shared definitions for the parallel-to-serial word-slot sequencer:
// state encoding, default idle/comma symbol and datapath widths.
package p2s_ctrl_pkg;

  typedef enum logic {
    P2S_OFF = 1'b0,
    P2S_RUN = 1'b1
  } p2s_state_e;

  localparam int unsigned P2S_WORD_W = 8;
  localparam int unsigned P2S_SEL_W  = 3;

  localparam logic [P2S_WORD_W-1:0] P2S_IDLE_WORD = 8'hBC;
  localparam logic [P2S_SEL_W-1:0]  P2S_LAST_BIT  = 3'd7;

endpackage

// File: rtl/mux_p2s.sv
// 8:1 bit multiplexer feeding the serial line; purely combinational.
module mux_p2s
  import p2s_ctrl_pkg::*;
(
  input  logic [P2S_SEL_W-1:0]  sel,
  input  logic [P2S_WORD_W-1:0] data_in,
  output logic                  data_out
);

  assign data_out = data_in[sel];

endmodule

// File: rtl/p2s_ctrl.sv
// Word-slot sequencer: one-word hold buffer, LSB-first slot shifting through
// mux_p2s, and idle-symbol fill whenever a slot boundary finds no pending word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// P2S_OFF | line idle, data_out=0; words may still be parked in hold
// P2S_RUN | slot in progress, cnt selects the bit on data_out
module p2s_ctrl
  import p2s_ctrl_pkg::*;
#(
  parameter logic [P2S_WORD_W-1:0] IDLE_WORD = P2S_IDLE_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [P2S_WORD_W-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [P2S_SEL_W-1:0]  sel,
  output logic                  data_out,
  output logic                  bit_valid,
  output logic                  word_start,
  output logic                  data_flag
);

  p2s_state_e            r_state,       r_state_nxt;
  logic [P2S_SEL_W-1:0]  r_cnt,         r_cnt_nxt;
  logic [P2S_WORD_W-1:0] r_shift,       r_shift_nxt;
  logic [P2S_WORD_W-1:0] r_hold,        r_hold_nxt;
  logic                  r_hold_full,   r_hold_full_nxt;
  logic                  r_cur_is_data, r_cur_is_data_nxt;

  logic w_xfer;
  logic w_load;
  logic w_mux_bit;

  assign w_xfer = valid_in && !r_hold_full;

  always_comb begin
    r_state_nxt       = r_state;
    r_cnt_nxt         = r_cnt;
    r_shift_nxt       = r_shift;
    r_hold_nxt        = r_hold;
    r_hold_full_nxt   = r_hold_full;
    r_cur_is_data_nxt = r_cur_is_data;
    w_load            = 1'b0;

    case (r_state)
      P2S_OFF: begin
        if (enable) begin
          w_load      = 1'b1;
          r_cnt_nxt   = '0;
          r_state_nxt = P2S_RUN;
        end
      end
      P2S_RUN: begin
        r_cnt_nxt = r_cnt + 3'd1;
        // enable only matters at the boundary so a slot is never cut short
        if (r_cnt == P2S_LAST_BIT) begin
          if (enable) begin
            w_load = 1'b1;
          end else begin
            r_state_nxt       = P2S_OFF;
            r_cnt_nxt         = '0;
            r_cur_is_data_nxt = 1'b0;
          end
        end
      end
      default: r_state_nxt = P2S_OFF;
    endcase

    if (w_xfer) begin
      r_hold_nxt      = data_in;
      r_hold_full_nxt = 1'b1;
    end

    // A word arriving on the load edge lands in hold, never bypasses to shift.
    if (w_load) begin
      if (r_hold_full) begin
        r_shift_nxt       = r_hold;
        r_hold_full_nxt   = 1'b0;
        r_cur_is_data_nxt = 1'b1;
      end else begin
        r_shift_nxt       = IDLE_WORD;
        r_cur_is_data_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= P2S_OFF;
      r_cnt         <= '0;
      r_shift       <= IDLE_WORD;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_cur_is_data <= 1'b0;
    end else begin
      r_state       <= r_state_nxt;
      r_cnt         <= r_cnt_nxt;
      r_shift       <= r_shift_nxt;
      r_hold        <= r_hold_nxt;
      r_hold_full   <= r_hold_full_nxt;
      r_cur_is_data <= r_cur_is_data_nxt;
    end
  end

  mux_p2s u_mux (
    .sel      (r_cnt),
    .data_in  (r_shift),
    .data_out (w_mux_bit)
  );

  assign ready_out  = !r_hold_full;
  assign sel        = r_cnt;
  assign bit_valid  = (r_state == P2S_RUN);
  assign data_out   = bit_valid ? w_mux_bit : 1'b0;
  assign word_start = bit_valid && (r_cnt == 3'd0);
  assign data_flag  = bit_valid && r_cur_is_data;

endmodule

// File: tb/tb_p2s_ctrl.sv
// Directed bench for p2s_ctrl: vector tables of slot sequences plus a
// hand-written streaming sequence with valid_in held high.
module tb_p2s_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [2:0] sel;
  logic       data_out;
  logic       bit_valid;
  logic       word_start;
  logic       data_flag;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] din;
    logic [7:0] exp;   // {ready, sel[2:0], data_out, bit_valid, word_start, data_flag}
  } vec_t;

  vec_t vq[$];

  p2s_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .sel        (sel),
    .data_out   (data_out),
    .bit_valid  (bit_valid),
    .word_start (word_start),
    .data_flag  (data_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack_exp(input logic rdy, input logic [2:0] s, input logic d,
                                          input logic bv, input logic ws, input logic fl);
    return {rdy, s, d, bv, ws, fl};
  endfunction

  task automatic add_vec(input logic rst, input logic en, input logic vld, input logic [7:0] din,
                         input logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.din = din; v.exp = exp;
    vq.push_back(v);
  endtask

  // One slot of nk cycles carrying 'word'; optional transfer at cycle xk,
  // enable dropped from cycle en_off_k on, ready_out expected per rdy[k].
  task automatic add_slot(input logic [7:0] word, input logic flag, input logic [7:0] rdy,
                          input int xk, input logic [7:0] xdata, input int en_off_k, input int nk);
    for (int k = 0; k < nk; k++) begin
      add_vec(1'b0, (k < en_off_k), (k == xk), (k == xk) ? xdata : 8'h00,
              pack_exp(rdy[k], 3'(k), word[k], 1'b1, (k == 0), flag));
    end
  endtask

  task automatic add_off(input logic rst, input logic rdy);
    add_vec(rst, 1'b0, 1'b0, 8'h00, pack_exp(rdy, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      reset    = vq[i].rst;
      enable   = vq[i].en;
      valid_in = vq[i].vld;
      data_in  = vq[i].din;
      @(posedge clk); #1;
      check($sformatf("%s[%0d] {rdy,sel,dout,bv,ws,flag}", tag, i),
            {ready_out, sel, data_out, bit_valid, word_start, data_flag}, vq[i].exp);
    end
    vq.delete();
  endtask

  logic [7:0] words[3];
  logic [7:0] slotw[4];
  int         acc_cyc[3];
  int         exp_acc[3];

  initial begin
    reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    @(posedge clk); #1;

    // Reset, idle fill, mid-slot transfer of A5, boundary transfer of 5A.
    add_off(1'b1, 1'b1);
    add_slot(IDLE,  1'b0, 8'hFF,        -1, 8'h00, 8, 8);
    add_slot(IDLE,  1'b0, 8'b0000_0111,  3, 8'hA5, 8, 8);
    add_slot(8'hA5, 1'b1, 8'hFF,        -1, 8'h00, 8, 8);
    add_slot(IDLE,  1'b0, 8'h00,         0, 8'h5A, 8, 8);
    add_slot(8'h5A, 1'b1, 8'hFF,        -1, 8'h00, 8, 8);
    run_table("t1");

    // Streaming 01, 80, FF with valid_in held high.
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    slotw[0] = IDLE;  slotw[1] = 8'h01; slotw[2] = 8'h80; slotw[3] = 8'hFF;
    exp_acc[0] = 0; exp_acc[1] = 9; exp_acc[2] = 17;
    begin
      int   j;
      logic pre_rdy;
      logic [7:0] w;
      j = 0;
      for (int cyc = 0; cyc < 32; cyc++) begin
        valid_in = (j < 3);
        data_in  = (j < 3) ? words[j] : 8'h00;
        enable   = 1'b1;
        pre_rdy  = ready_out;
        @(posedge clk); #1;
        if (pre_rdy && valid_in && j < 3) begin
          acc_cyc[j] = cyc;
          j++;
        end
        w = slotw[cyc / 8];
        check($sformatf("stream[%0d] {dout,ws,flag}", cyc), {5'd0, data_out, word_start, data_flag},
              {5'd0, w[cyc % 8], (cyc % 8 == 0), (cyc >= 8)});
      end
      check("stream accepted count", 8'(j), 8'd3);
      for (int a = 0; a < 3; a++)
        check($sformatf("stream accept cycle %0d", a), 8'(acc_cyc[a]), 8'(exp_acc[a]));
    end

    // Enable drop mid-word, parked word sent first on re-enable, reset mid-slot.
    add_slot(IDLE,  1'b0, 8'b0000_0011,  2, 8'h3C, 8, 8);
    add_slot(8'h3C, 1'b1, 8'b0000_0001,  1, 8'h77, 3, 8);
    add_off(1'b0, 1'b0);
    add_off(1'b0, 1'b0);
    add_off(1'b0, 1'b0);
    add_slot(8'h77, 1'b1, 8'b0000_0001,  1, 8'h99, 8, 6);
    add_off(1'b1, 1'b1);
    add_slot(IDLE,  1'b0, 8'hFF,        -1, 8'h00, 8, 8);
    add_slot(IDLE,  1'b0, 8'hFF,        -1, 8'h00, 8, 8);
    run_table("t2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
